// File: rtl/ram_stream_pkg.sv
`default_nettype none
// ============================================================================
//  Module  : ram_stream_pkg
//  Purpose : Shared types and constants for the RAM stream reader: the
//            controller state enumeration, the output-buffer depth and a
//            helper that performs the optional transfer bounds check.
//  Ports   : none (package)
//  Revision: 1.0 - initial release
// ============================================================================
package ram_stream_pkg;

   // Output buffer depth. Two entries are enough to cover the one-cycle RAM
   // read latency while sustaining one word per cycle.
   localparam int unsigned BUF_DEPTH = 2;
   localparam int unsigned BUF_PTR_W = (BUF_DEPTH > 1) ? $clog2(BUF_DEPTH) : 1;
   localparam int unsigned BUF_LVL_W = $clog2(BUF_DEPTH + 1);

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_READ  = 2'd1,
      ST_DRAIN = 2'd2,
      ST_DONE  = 2'd3
   } state_t;

   // True when [base, base+count) does not fit inside a RAM of `length` words.
   // The second term is only evaluated meaningfully when base < length, which
   // the first term guarantees, so the subtraction cannot underflow.
   function automatic logic out_of_bounds(input logic [31:0] base,
                                          input logic [31:0] count,
                                          input logic [31:0] length);
      return (base >= length) || (count > (length - base));
   endfunction

endpackage
`default_nettype wire

// File: rtl/stream_skid_fifo.sv
`default_nettype none
// ============================================================================
//  Module  : stream_skid_fifo
//  Purpose : Small synchronous FIFO (BUF_DEPTH entries) that holds words read
//            from the RAM until the stream consumer accepts them. Push and pop
//            may occur in the same cycle, including when full.
//  Ports   : clk, reset        - clock, synchronous active-high reset
//            push, push_data   - write a word (ignored when full and no pop)
//            pop               - remove the head word (ignored when empty)
//            pop_data          - head word, stable until popped
//            full, empty, level- occupancy status
//  Revision: 1.0 - initial release
// ============================================================================
module stream_skid_fifo
   import ram_stream_pkg::*;
#(
   parameter int WIDTH = 32
)
(
   input  logic                 clk,
   input  logic                 reset,
   input  logic                 push,
   input  logic [WIDTH-1:0]     push_data,
   input  logic                 pop,
   output logic [WIDTH-1:0]     pop_data,
   output logic                 full,
   output logic                 empty,
   output logic [BUF_LVL_W-1:0] level
);

   localparam logic [BUF_PTR_W-1:0] c_last_ptr = BUF_PTR_W'(BUF_DEPTH - 1);
   localparam logic [BUF_LVL_W-1:0] c_full_lvl = BUF_LVL_W'(BUF_DEPTH);

   logic [WIDTH-1:0]     mem_q [BUF_DEPTH];
   logic [BUF_PTR_W-1:0] wr_ptr_q, wr_ptr_d;
   logic [BUF_PTR_W-1:0] rd_ptr_q, rd_ptr_d;
   logic [BUF_LVL_W-1:0] level_q, level_d;
   logic                 do_push;
   logic                 do_pop;

   assign empty    = (level_q == '0);
   assign full     = (level_q == c_full_lvl);
   assign level    = level_q;
   assign pop_data = mem_q[rd_ptr_q];

   assign do_pop  = pop && !empty;
   // A push into a full FIFO is legal only when the head leaves this cycle.
   assign do_push = push && (!full || do_pop);

   always_comb begin
      wr_ptr_d = wr_ptr_q;
      rd_ptr_d = rd_ptr_q;
      level_d  = level_q;
      if (do_push) begin
         wr_ptr_d = (wr_ptr_q == c_last_ptr) ? '0 : wr_ptr_q + BUF_PTR_W'(1);
      end
      if (do_pop) begin
         rd_ptr_d = (rd_ptr_q == c_last_ptr) ? '0 : rd_ptr_q + BUF_PTR_W'(1);
      end
      if (do_push && !do_pop) begin
         level_d = level_q + BUF_LVL_W'(1);
      end else if (do_pop && !do_push) begin
         level_d = level_q - BUF_LVL_W'(1);
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         level_q  <= '0;
      end else begin
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
         level_q  <= level_d;
      end
   end

   // Storage needs no reset: occupancy tracking decides what is valid.
   always_ff @(posedge clk) begin
      if (do_push) begin
         mem_q[wr_ptr_q] <= push_data;
      end
   end

endmodule
`default_nettype wire

// File: rtl/ram_stream_reader.sv
`default_nettype none
// ============================================================================
//  Module  : ram_stream_reader
//  Purpose : Reads `count` consecutive words starting at `base` from a RAM
//            with one-cycle read latency and presents them, in ascending
//            address order, on a valid/ready stream. Sustains one word per
//            cycle when the consumer is always ready.
//  Ports   : clk, reset                 - clock, synchronous active-high reset
//            start, base, count         - transfer request (taken in IDLE)
//            busy, done, err            - status (done/err pulse at end)
//            ram_we, ram_oe, ram_address, ram_din, ram_dout, ram_length
//                                       - RAM port (read-only use)
//            out_valid, out_ready, out_data - output stream
//  Config  : RAM_STREAM_READER_BOUNDS_EN - when defined, requests that fall
//            outside [0, ram_length) are rejected with done=1, err=1 and no
//            RAM reads. When undefined, err is always 0 and addresses wrap
//            modulo 2^32.
//  Revision: 1.0 - initial release
// ============================================================================
module ram_stream_reader
   import ram_stream_pkg::*;
#(
   parameter int WIDTH = 32,
   parameter int DEPTH = 10
)
(
   input  logic             clk,
   input  logic             reset,
   input  logic             start,
   input  logic [31:0]      base,
   input  logic [31:0]      count,
   output logic             busy,
   output logic             done,
   output logic             err,
   output logic             ram_we,
   output logic             ram_oe,
   output logic [31:0]      ram_address,
   output logic [WIDTH-1:0] ram_din,
   input  logic [WIDTH-1:0] ram_dout,
   input  logic [31:0]      ram_length,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [WIDTH-1:0] out_data
);

   localparam logic [BUF_LVL_W:0] c_buf_depth = (BUF_LVL_W + 1)'(BUF_DEPTH);

   state_t               state_q, state_d;
   logic [31:0]          addr_q, addr_d;        // next address to issue
   logic [31:0]          remaining_q, remaining_d; // reads still to issue
   logic                 inflight_q, inflight_d;   // read issued last cycle
   logic                 busy_q, busy_d;
   logic                 done_q, done_d;
   logic                 err_q, err_d;

   logic                 reject;
   logic                 issue;
   logic [31:0]          issue_addr;
   logic                 fifo_pop;
   logic                 fifo_full;
   logic                 fifo_empty;
   logic [BUF_LVL_W-1:0] fifo_level;
   logic [BUF_LVL_W:0]   pending;
   logic                 room;
   logic                 unused_cfg;

   // The RAM is only ever read.
   assign ram_we  = 1'b0;
   assign ram_din = '0;

`ifdef RAM_STREAM_READER_BOUNDS_EN
   assign reject = out_of_bounds(base, count, ram_length);
`else
   assign reject = 1'b0;
`endif

   // ram_length only matters for the bounds check; DEPTH documents the
   // attached RAM's address decode, which is where out-of-range addresses alias.
   assign unused_cfg = ^{ram_length, 32'(DEPTH)};

   assign fifo_pop = out_valid && out_ready;

   // Words committed to the buffer after this cycle: stored + landing - leaving.
   // A new read is allowed only if its word will still have a slot when it
   // lands, which keeps the buffer from ever overflowing.
   assign pending = {1'b0, fifo_level}
                  + {{BUF_LVL_W{1'b0}}, inflight_q}
                  - {{BUF_LVL_W{1'b0}}, fifo_pop};
   assign room    = (pending < c_buf_depth);

   // The first read is issued in the start cycle itself so that the first
   // word reaches the stream two cycles after start.
   always_comb begin
      issue      = 1'b0;
      issue_addr = addr_q;
      if (!reset) begin
         unique case (state_q)
            ST_IDLE: begin
               if (start && (count != 32'd0) && !reject) begin
                  issue      = 1'b1;
                  issue_addr = base;
               end
            end
            ST_READ: begin
               issue = (remaining_q != 32'd0) && room;
            end
            default: begin
               issue = 1'b0;
            end
         endcase
      end
   end

   assign ram_oe      = issue;
   assign ram_address = issue ? issue_addr : 32'd0;

   always_comb begin
      state_d     = state_q;
      addr_d      = addr_q;
      remaining_d = remaining_q;
      inflight_d  = issue;
      unique case (state_q)
         ST_IDLE: begin
            if (start) begin
               if ((count == 32'd0) || reject) begin
                  state_d = ST_DONE;
               end else begin
                  state_d     = ST_READ;
                  addr_d      = base + 32'd1;
                  remaining_d = count - 32'd1;
               end
            end
         end
         ST_READ: begin
            if (issue) begin
               addr_d      = addr_q + 32'd1;
               remaining_d = remaining_q - 32'd1;
            end
            if ((remaining_q == 32'd0) || (issue && (remaining_q == 32'd1))) begin
               state_d = ST_DRAIN;
            end
         end
         ST_DRAIN: begin
            if (fifo_empty && !inflight_q) begin
               state_d = ST_DONE;
            end
         end
         ST_DONE: begin
            state_d = ST_IDLE;
         end
         default: begin
            state_d = ST_IDLE;
         end
      endcase
      busy_d = (state_d == ST_READ) || (state_d == ST_DRAIN);
      done_d = (state_d == ST_DONE);
      // Only a rejected request goes straight from IDLE to DONE with an error.
      err_d  = (state_q == ST_IDLE) && start && reject;
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q     <= ST_IDLE;
         addr_q      <= 32'd0;
         remaining_q <= 32'd0;
         inflight_q  <= 1'b0;
         busy_q      <= 1'b0;
         done_q      <= 1'b0;
         err_q       <= 1'b0;
      end else begin
         state_q     <= state_d;
         addr_q      <= addr_d;
         remaining_q <= remaining_d;
         inflight_q  <= inflight_d;
         busy_q      <= busy_d;
         done_q      <= done_d;
         err_q       <= err_d;
      end
   end

   assign busy = busy_q;
   assign done = done_q;
   assign err  = err_q;

   // Read data is captured exactly one cycle after its read was issued.
   stream_skid_fifo #(
      .WIDTH (WIDTH)
   ) u_buf (
      .clk       (clk),
      .reset     (reset),
      .push      (inflight_q),
      .push_data (ram_dout),
      .pop       (fifo_pop),
      .pop_data  (out_data),
      .full      (fifo_full),
      .empty     (fifo_empty),
      .level     (fifo_level)
   );

   assign out_valid = !fifo_empty;

   // Full is implied by the issue throttle; it is kept on the buffer for reuse.
   logic unused_full;
   assign unused_full = fifo_full | unused_cfg;

endmodule
`default_nettype wire

// File: tb/tb_ram_stream_reader.sv
`default_nettype none
// ============================================================================
//  Module  : tb_ram_stream_reader
//  Purpose : Directed self-checking bench for ram_stream_reader with a
//            1024-word synchronous RAM model preloaded with mem[i] = i.
//  Revision: 1.0 - initial release
// ============================================================================
module tb_ram_stream_reader;

   logic        clk = 1'b0;
   logic        reset;
   logic        start;
   logic [31:0] base;
   logic [31:0] count;
   logic        busy, done, err;
   logic        ram_we, ram_oe;
   logic [31:0] ram_address;
   logic [31:0] ram_din;
   logic [31:0] ram_dout;
   logic [31:0] ram_length = 32'd1024;
   logic        out_valid, out_ready;
   logic [31:0] out_data;

   int total = 0;
   int bad   = 0;

   logic [31:0] mem [1024];
   logic [31:0] got_q [$];
   logic [31:0] addr_log [$];
   int          done_cyc;
   int          n_done;
   logic        err_seen;
   int          first_valid;
   int          viol;

   always #5 clk = ~clk;

   ram_stream_reader #(
      .WIDTH (32),
      .DEPTH (10)
   ) dut (
      .clk         (clk),
      .reset       (reset),
      .start       (start),
      .base        (base),
      .count       (count),
      .busy        (busy),
      .done        (done),
      .err         (err),
      .ram_we      (ram_we),
      .ram_oe      (ram_oe),
      .ram_address (ram_address),
      .ram_din     (ram_din),
      .ram_dout    (ram_dout),
      .ram_length  (ram_length),
      .out_valid   (out_valid),
      .out_ready   (out_ready),
      .out_data    (out_data)
   );

   // Synchronous RAM: 10 address bits decoded, data one cycle after address.
   always @(posedge clk) begin
      if (ram_oe) ram_dout <= mem[ram_address[9:0]];
   end

   task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got=%0h expected=%0h", tag, act, exp);
      end
   endtask

   // Runs one transfer; cycle 0 is the start cycle. mode 0: out_ready=1,
   // mode 1: out_ready pattern 1,0,0,1 repeating. Stops in the done cycle.
   task automatic run_xfer(input logic [31:0] b, input logic [31:0] n, input int mode);
      int   outstanding;
      logic finished;
      got_q.delete();
      addr_log.delete();
      done_cyc    = -1;
      n_done      = 0;
      err_seen    = 1'b0;
      first_valid = -1;
      viol        = 0;
      outstanding = 0;
      finished    = 1'b0;
      for (int cyc = 0; cyc < 200 && !finished; cyc++) begin
         @(negedge clk);
         start     = (cyc == 0);
         base      = b;
         count     = n;
         out_ready = (mode == 0) ? 1'b1 : ((cyc % 4 == 0) || (cyc % 4 == 3));
         #1;
         if (out_valid && first_valid < 0) first_valid = cyc;
         if (out_valid && out_ready) begin
            got_q.push_back(out_data);
            outstanding--;
         end
         if (ram_oe) begin
            if (outstanding >= 2) viol++;
            addr_log.push_back(ram_address);
            outstanding++;
         end
         if (done) begin
            n_done++;
            done_cyc = cyc;
            err_seen = err;
            finished = 1'b1;
         end
      end
      start = 1'b0;
      chk("done_seen", {31'd0, finished}, 32'd1);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: got=timeout expected=finish");
      $fatal(1, "watchdog expired");
   end

   initial begin
      for (int i = 0; i < 1024; i++) mem[i] = 32'(i);
      reset     = 1'b1;
      start     = 1'b0;
      base      = 32'd0;
      count     = 32'd0;
      out_ready = 1'b0;
      repeat (3) @(negedge clk);
      reset = 1'b0;
      #1;
      chk("rst_busy",  {31'd0, busy},      32'd0);
      chk("rst_done",  {31'd0, done},      32'd0);
      chk("rst_err",   {31'd0, err},       32'd0);
      chk("rst_valid", {31'd0, out_valid}, 32'd0);
      chk("rst_oe",    {31'd0, ram_oe},    32'd0);
      chk("rst_addr",  ram_address,        32'd0);
      chk("rst_we",    {31'd0, ram_we},    32'd0);
      chk("rst_din",   ram_din,            32'd0);

      // Full-rate transfer: words 4..11, first valid at cycle 2, done at 11.
      run_xfer(32'd4, 32'd8, 0);
      chk("fr_count", 32'(got_q.size()), 32'd8);
      for (int k = 0; k < 8 && k < got_q.size(); k++) chk("fr_data", got_q[k], 32'(4 + k));
      for (int k = 0; k < 8 && k < addr_log.size(); k++) chk("fr_addr", addr_log[k], 32'(4 + k));
      chk("fr_first",  32'(first_valid), 32'd2);
      chk("fr_donecy", 32'(done_cyc),    32'd11);
      chk("fr_err",    {31'd0, err_seen}, 32'd0);
      chk("fr_viol",   32'(viol),        32'd0);

      // Back-to-back, throttled consumer: same sequence, no overrun.
      run_xfer(32'd4, 32'd8, 1);
      chk("tg_count", 32'(got_q.size()), 32'd8);
      for (int k = 0; k < 8 && k < got_q.size(); k++) chk("tg_data", got_q[k], 32'(4 + k));
      chk("tg_reads", 32'(addr_log.size()), 32'd8);
      chk("tg_err",   {31'd0, err_seen}, 32'd0);
      chk("tg_viol",  32'(viol),        32'd0);
      chk("tg_once",  32'(n_done),      32'd1);

      // Zero-length request.
      run_xfer(32'd4, 32'd0, 0);
      chk("z_donecy", 32'(done_cyc),        32'd1);
      chk("z_err",    {31'd0, err_seen},    32'd0);
      chk("z_reads",  32'(addr_log.size()), 32'd0);
      chk("z_valid",  32'(first_valid),     32'hFFFF_FFFF);

`ifdef RAM_STREAM_READER_BOUNDS_EN
      run_xfer(32'd1020, 32'd8, 0);
      chk("ob_donecy", 32'(done_cyc),        32'd1);
      chk("ob_err",    {31'd0, err_seen},    32'd1);
      chk("ob_reads",  32'(addr_log.size()), 32'd0);
      chk("ob_words",  32'(got_q.size()),    32'd0);
      run_xfer(32'd1016, 32'd8, 0);
      chk("ib_count", 32'(got_q.size()), 32'd8);
      for (int k = 0; k < 8 && k < got_q.size(); k++) chk("ib_data", got_q[k], 32'(1016 + k));
      chk("ib_err",   {31'd0, err_seen}, 32'd0);
`else
      // Address wrap at 2^32; data aliases through the 10-bit RAM decode.
      run_xfer(32'hFFFF_FFFE, 32'd4, 0);
      chk("wr_reads", 32'(addr_log.size()), 32'd4);
      if (addr_log.size() == 4) begin
         chk("wr_addr0", addr_log[0], 32'hFFFF_FFFE);
         chk("wr_addr1", addr_log[1], 32'hFFFF_FFFF);
         chk("wr_addr2", addr_log[2], 32'h0000_0000);
         chk("wr_addr3", addr_log[3], 32'h0000_0001);
      end
      chk("wr_count", 32'(got_q.size()), 32'd4);
      if (got_q.size() == 4) begin
         chk("wr_data0", got_q[0], 32'd1022);
         chk("wr_data1", got_q[1], 32'd1023);
         chk("wr_data2", got_q[2], 32'd0);
         chk("wr_data3", got_q[3], 32'd1);
      end
      chk("wr_err", {31'd0, err_seen}, 32'd0);
`endif

      // Reset while the third word (6) is on the stream.
      for (int cyc = 0; cyc < 5; cyc++) begin
         @(negedge clk);
         start     = (cyc == 0);
         base      = 32'd4;
         count     = 32'd8;
         out_ready = 1'b1;
         reset     = (cyc == 4);
         #1;
         if (cyc == 4) begin
            chk("mr_valid", {31'd0, out_valid}, 32'd1);
            chk("mr_word",  out_data, 32'd6);
         end
      end
      @(negedge clk);
      reset = 1'b0;
      start = 1'b0;
      #1;
      chk("mr_outv", {31'd0, out_valid}, 32'd0);
      chk("mr_busy", {31'd0, busy},      32'd0);
      chk("mr_done", {31'd0, done},      32'd0);
      chk("mr_oe",   {31'd0, ram_oe},    32'd0);
      n_done = 0;
      for (int cyc = 0; cyc < 12; cyc++) begin
         @(negedge clk);
         #1;
         if (done) n_done++;
      end
      chk("mr_nodone", 32'(n_done), 32'd0);

      run_xfer(32'd0, 32'd2, 0);
      chk("pr_count", 32'(got_q.size()), 32'd2);
      for (int k = 0; k < 2 && k < got_q.size(); k++) chk("pr_data", got_q[k], 32'(k));
      chk("pr_err", {31'd0, err_seen}, 32'd0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
`default_nettype wire
